// File: rtl/fetch_unit.sv
// fetch_unit: multicycle instruction fetch with PC, latency counter and valid/ready hand-off.
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned PCs to EXC_VECTOR.
`timescale 1ns/1ps
module fetch_unit #(
  parameter int unsigned      XLEN         = 32,
  parameter int unsigned      MEM_LATENCY  = 1,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
  parameter logic [XLEN-1:0]  EXC_VECTOR   = 'h80
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [XLEN-1:0] mem_addr_o,
  output logic            mem_rd_o,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic            misalign_o,
  output logic [1:0]      state_out_o
);
  typedef enum logic [1:0] {FETCH = 2'd0, WAIT = 2'd1, HOLD = 2'd2, TRAP = 2'd3} state_e;
  state_e          state_q;
  logic [3:0]      cnt_q;
  logic [XLEN-1:0] pc_q, instr_q, instr_pc_q;
  logic            valid_q, misal;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign misal      = pc_q[1:0] != 2'b00;
  assign mem_addr_o = pc_q;
  assign misalign_o = rst_ni && state_q == TRAP;
`else
  assign misal      = 1'b0;
  assign mem_addr_o = {pc_q[XLEN-1:2], 2'b00};
  assign misalign_o = 1'b0;
`endif
  // read strobe is forced low while reset is held, even though the state is FETCH
  assign mem_rd_o      = rst_ni && state_q == FETCH && !misal;
  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;
  assign instr_valid_o = valid_q;
  assign pc_o          = pc_q;
  assign state_out_o   = state_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= FETCH;
      cnt_q      <= '0;
      pc_q       <= RESET_VECTOR;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
    end else if (redirect_valid_i) begin
      state_q <= FETCH;
      cnt_q   <= '0;
      pc_q    <= redirect_pc_i;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        FETCH:
          if (misal) begin
            state_q <= TRAP;
            pc_q    <= EXC_VECTOR;
          end else begin
            state_q <= WAIT;
            cnt_q   <= 4'(MEM_LATENCY - 1);
          end
        WAIT:
          if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
          else begin
            instr_q    <= mem_rdata_i;
            instr_pc_q <= pc_q;
            pc_q       <= pc_q + XLEN'(4);
            valid_q    <= 1'b1;
            state_q    <= HOLD;
          end
        HOLD:
          if (instr_ready_i) begin
            valid_q <= 1'b0;
            state_q <= FETCH;
          end
        TRAP: state_q <= FETCH;
        default: state_q <= FETCH;
      endcase
    end
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised multicycle instruction-fetch stage; the successor to the fixed PC register plus PC mux plus memory-read path in the CPU top.
- Owns the PC and issues reads to instruction memory with a configurable memory latency.
- Hands fetched instructions to the control/decode side over a valid/ready handshake.
- Accepts branch/jump/exception redirects and optionally traps misaligned PCs to an exception vector.

Parameters:
- XLEN, 32: datapath/address width in bits (>= 8).
- MEM_LATENCY, 1: cycles from the address cycle to valid mem_rdata; legal range 1..15.
- RESET_VECTOR, 0: PC value after reset.
- EXC_VECTOR, 'h80: PC loaded on a misaligned-fetch trap.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- redirect_valid  in  1  load redirect_pc this cycle; highest priority.
- redirect_pc  in  XLEN  new PC for the redirect.
- mem_addr  out  XLEN  instruction memory address.
- mem_rd  out  1  memory read strobe.
- mem_rdata  in  XLEN  memory read data.
- instr  out  XLEN  captured instruction word.
- instr_pc  out  XLEN  PC of the captured instruction.
- instr_valid  out  1  instr/instr_pc are valid.
- instr_ready  in  1  consumer accepts the instruction.
- pc  out  XLEN  current fetch PC.
- misalign  out  1  one-cycle trap pulse.
- state_out  out  2  FSM state, for debug.

Behaviour:
- Reset (reset=0, asynchronous): pc=RESET_VECTOR, state=FETCH, instr=0, instr_pc=0, instr_valid=0, counter=0. While in reset, mem_rd=0 and misalign=0.
- State encodings: FETCH=0, WAIT=1, HOLD=2, TRAP=3; state_out mirrors the state register.
- FETCH:
  - mem_rd=1 and mem_addr=pc (Moore outputs).
  - Next cycle: state=WAIT, counter=MEM_LATENCY-1.
- WAIT:
  - mem_rd=0.
  - If counter!=0, decrement the counter.
  - If counter==0, on the clock edge: instr<=mem_rdata, instr_pc<=pc, pc<=pc+4 (modulo 2^XLEN; wrap from all-ones-minus-3 to 0), instr_valid<=1, state<=HOLD.
- HOLD:
  - instr_valid=1 and instr is held stable.
  - If instr_ready=1: instr_valid<=0 and state<=FETCH.
  - Otherwise stay in HOLD indefinitely.
- Latency: instr_valid rises MEM_LATENCY+1 cycles after the FETCH cycle begins. Back-to-back throughput is one instruction per MEM_LATENCY+2 cycles when instr_ready is held at 1.
- Redirect (any state, redirect_valid=1): pc<=redirect_pc, state<=FETCH, counter<=0, instr_valid<=0.
  - Any in-flight read is discarded; a capture scheduled on the same edge is dropped.
  - In HOLD with instr_ready=1 on the same cycle, the handshake counts as completed and the redirect still applies.
- mem_rd is never asserted outside FETCH.
- Reset asserted mid-read abandons the read immediately; no capture occurs.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - In FETCH, if pc[1:0]!=0: mem_rd=0 and the next state is TRAP, with pc<=EXC_VECTOR.
  - In TRAP, misalign=1 for exactly one cycle, then the next state is FETCH.
  - A redirect during TRAP overrides: pc<=redirect_pc, and misalign is still pulsed.
- Not defined:
  - mem_addr={pc[XLEN-1:2],2'b00}; misalign is tied to 0.
  - TRAP is unreachable and pc increments normally.

Test Plan:
- Reset release, MEM_LATENCY=1, memory returns 0x2000_0001 at address 0, instr_ready=1 -> mem_rd at cycle 0 with mem_addr=0; instr_valid=1 at cycle 2 with instr=0x2000_0001 and instr_pc=0; pc=4; next FETCH at address 4.
- MEM_LATENCY=3, instr_ready=0 for 5 cycles after valid -> instr_valid asserted at cycle 4 and held with instr stable; no mem_rd while stalled; FETCH resumes the cycle after instr_ready=1.
- redirect_valid=1 with redirect_pc=0x40 during WAIT -> no capture; next mem_addr=0x40; the old data never appears on instr.
- HOLD with instr_ready=1 and redirect_valid=1 (redirect_pc=0x100) on the same cycle -> instr_valid drops; next fetch from 0x100.
- With FETCH_MISALIGN_TRAP_EN, redirect to 0x6 -> no mem_rd; misalign=1 for one cycle; next fetch from 0x80. Without the macro -> mem_addr=0x4, misalign stays 0.
- pc=0xFFFF_FFFC fetch completes -> pc wraps to 0; reset asserted during WAIT -> instr_valid=0 and pc=RESET_VECTOR immediately.
